fetch_ctrl: RTL and testbench

//   Fetch sequencer between PC generation and instruction memory. Owns the

---
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request bus between the fetch sequencer and imem.
// Request and address are held by the master until the slave acks.
interface fetch_ctrl_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic                     imem_req;
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic                     imem_ack;
   logic [DATA_WIDTH-1:0]    imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives imem requests, buffers
// returned words in a 2-entry queue and squashes stale fetches on redirect.
module fetch_ctrl #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
   parameter int PC_STEP       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   input  logic                     stall,
   fetch_ctrl_if.master             imem,
   output logic                     instr_valid,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc
);
   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;

   typedef enum logic {
      FETCH,
      DRAIN
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] pend_pc_q, pend_pc_d;
   logic          go_q;
   logic          req_q;

   logic          h_v_q, t_v_q;
   logic [AW-1:0] h_pc_q, t_pc_q;
   logic [DW-1:0] h_dat_q, t_dat_q;

   logic [1:0]    occ;
   logic          pop;
   logic          new_req;
   logic          req;
   logic          ack;
   logic          push;

   assign occ = {1'b0, h_v_q} + {1'b0, t_v_q};
   assign pop = h_v_q & ~stall & ~redirect_valid;

   // A new request never starts in a redirect cycle, so the
   // target is always fetched from a clean FETCH state.
   assign new_req = go_q & (state_q == FETCH) & ~req_q
                  & ~redirect_valid
                  & ((occ != 2'd2) | pop);

   assign req  = req_q | new_req;
   assign ack  = req & imem.imem_ack;
   assign push = (state_q == FETCH) & ack & ~redirect_valid;

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;

   assign instr_valid = h_v_q;
   assign instr       = h_dat_q;
   assign instr_pc    = h_pc_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      unique case (state_q)
         FETCH: begin
            if (redirect_valid) begin
               if (!req_q || ack) begin
                  fetch_pc_d = redirect_pc;
               end else begin
                  pend_pc_d = redirect_pc;
                  state_d   = DRAIN;
               end
            end else if (ack) begin
               fetch_pc_d = fetch_pc_q + AW'(PC_STEP);
            end
         end
         DRAIN: begin
            if (ack) begin
               fetch_pc_d = redirect_valid ? redirect_pc
                                           : pend_pc_q;
               state_d    = FETCH;
            end else if (redirect_valid) begin
               pend_pc_d = redirect_pc;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= RESET_PC;
         go_q       <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         go_q       <= 1'b1;
         req_q      <= req & ~ack;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_v_q   <= 1'b0;
         t_v_q   <= 1'b0;
         h_pc_q  <= '0;
         t_pc_q  <= '0;
         h_dat_q <= '0;
         t_dat_q <= '0;
      end else if (redirect_valid) begin
         h_v_q <= 1'b0;
         t_v_q <= 1'b0;
      end else if (pop) begin
         if (t_v_q) begin
            h_pc_q  <= t_pc_q;
            h_dat_q <= t_dat_q;
            if (push) begin
               t_pc_q  <= fetch_pc_q;
               t_dat_q <= imem.imem_rdata;
            end else begin
               t_v_q <= 1'b0;
            end
         end else if (push) begin
            h_pc_q  <= fetch_pc_q;
            h_dat_q <= imem.imem_rdata;
         end else begin
            h_v_q <= 1'b0;
         end
      end else if (push) begin
         if (!h_v_q) begin
            h_v_q   <= 1'b1;
            h_pc_q  <= fetch_pc_q;
            h_dat_q <= imem.imem_rdata;
         end else begin
            t_v_q   <= 1'b1;
            t_pc_q  <= fetch_pc_q;
            t_dat_q <= imem.imem_rdata;
         end
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst)
      !(push && (occ == 2'd2) && !pop)
   );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a variable-latency imem model.
// Expected fetch PCs are queued at stimulus time and checked on each pop.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rv = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] rpc = '0;
   logic        iv;
   logic [31:0] ins;
   logic [31:0] ipc;
   logic [31:0] mon_e;

   int lat = 0;
   int wcnt = 0;
   int npop = 0;
   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];

   fetch_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) imem ();

   fetch_ctrl #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH(32),
      .RESET_PC(32'h0),
      .PC_STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .redirect_valid(rv),
      .redirect_pc(rpc),
      .stall(stall),
      .imem(imem),
      .instr_valid(iv),
      .instr(ins),
      .instr_pc(ipc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
   endfunction

   assign imem.imem_ack   = imem.imem_req && (wcnt >= lat);
   assign imem.imem_rdata = mem_f(imem.imem_addr);

   always @(posedge clk) begin
      if (!imem.imem_req || imem.imem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst && iv && !stall && !rv) begin
         chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_pc", ipc, mon_e);
            chk("sb_data", ins, mem_f(mon_e));
         end
         npop++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rv = 1'b0;
      stall = 1'b0;
      rpc = '0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      npop = 0;
      rst = 1'b1;
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   task automatic wait_pops(input string tag, input int n,
                            input int budget);
      int c = 0;
      while (npop < n && c < budget) begin
         step();
         c++;
      end
      chk(tag, 32'(npop >= n), 32'd1);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem.imem_req), 32'd0);
      chk("rst_addr", imem.imem_addr, 32'h0);
      chk("rst_iv", 32'(iv), 32'd0);
      chk("rst_instr", ins, 32'h0);
      chk("rst_ipc", ipc, 32'h0);
      do_reset();
      #1;
      chk("rel_noreq", 32'(imem.imem_req), 32'd0);

      // zero-wait streaming
      lat = 0;
      push_seq(32'h0, 16);
      step();
      @(negedge clk);
      chk("t1_req", 32'(imem.imem_req), 32'd1);
      chk("t1_addr", imem.imem_addr, 32'h0);
      step();
      @(negedge clk);
      chk("t1_iv", 32'(iv), 32'd1);
      chk("t1_ipc", ipc, 32'h0);
      repeat (10) step();
      stall = 1'b1;
      chk("t1_rate", 32'(npop), 32'd10);

      // stall fills the queue and blocks requests
      do_reset();
      stall = 1'b1;
      lat = 0;
      push_seq(32'h0, 12);
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_req", 32'(imem.imem_req), 32'd0);
         chk("t2_ipc", ipc, 32'h0);
         chk("t2_ins", ins, mem_f(32'h0));
         step();
      end
      step();
      stall = 1'b0;
      repeat (6) step();
      stall = 1'b1;
      chk("t2_cnt", 32'(npop), 32'd6);

      // redirect during a 3-cycle wait
      do_reset();
      lat = 3;
      push_seq(32'h100, 4);
      step();
      @(negedge clk);
      chk("t3_req", 32'(imem.imem_req), 32'd1);
      step();
      rv = 1'b1;
      rpc = 32'h100;
      @(negedge clk);
      chk("t3_hold0", imem.imem_addr, 32'h0);
      step();
      rv = 1'b0;
      @(negedge clk);
      chk("t3_hold1", imem.imem_addr, 32'h0);
      chk("t3_holdr", 32'(imem.imem_req), 32'd1);
      step();
      @(negedge clk);
      chk("t3_hold2", imem.imem_addr, 32'h0);
      step();
      @(negedge clk);
      chk("t3_new", imem.imem_addr, 32'h100);
      chk("t3_newr", 32'(imem.imem_req), 32'd1);
      wait_pops("t3_pops", 2, 40);
      stall = 1'b1;

      // two redirects in one drain, last wins
      do_reset();
      lat = 3;
      push_seq(32'h300, 3);
      step();
      step();
      rv = 1'b1;
      rpc = 32'h200;
      step();
      rpc = 32'h300;
      step();
      rv = 1'b0;
      @(negedge clk);
      chk("t4_hold", imem.imem_addr, 32'h0);
      step();
      @(negedge clk);
      chk("t4_new", imem.imem_addr, 32'h300);
      wait_pops("t4_pops", 2, 40);
      stall = 1'b1;

      // redirect coincident with the draining ack
      do_reset();
      lat = 2;
      push_seq(32'h600, 2);
      step();
      step();
      rv = 1'b1;
      rpc = 32'h500;
      step();
      rpc = 32'h600;
      step();
      rv = 1'b0;
      @(negedge clk);
      chk("t4b_new", imem.imem_addr, 32'h600);
      chk("t4b_req", 32'(imem.imem_req), 32'd1);
      wait_pops("t4b_pops", 2, 40);
      stall = 1'b1;

      // redirect with full queue and same-cycle pop
      do_reset();
      lat = 0;
      stall = 1'b1;
      repeat (4) step();
      stall = 1'b0;
      rv = 1'b1;
      rpc = 32'h40;
      push_seq(32'h40, 4);
      step();
      rv = 1'b0;
      @(negedge clk);
      chk("t5_flush", 32'(iv), 32'd0);
      chk("t5_addr", imem.imem_addr, 32'h40);
      step();
      @(negedge clk);
      chk("t5_iv", 32'(iv), 32'd1);
      chk("t5_ipc", ipc, 32'h40);
      wait_pops("t5_pops", 3, 20);
      stall = 1'b1;

      // PC wrap
      do_reset();
      lat = 0;
      rv = 1'b1;
      rpc = 32'hFFFF_FFFC;
      push_seq(32'hFFFF_FFFC, 3);
      step();
      rv = 1'b0;
      @(negedge clk);
      chk("t6_top", imem.imem_addr, 32'hFFFF_FFFC);
      step();
      @(negedge clk);
      chk("t6_wrap", imem.imem_addr, 32'h0);
      wait_pops("t6_pops", 3, 20);
      stall = 1'b1;

      // async reset during a wait
      do_reset();
      lat = 5;
      step();
      @(negedge clk);
      chk("t7_req", 32'(imem.imem_req), 32'd1);
      step();
      rst = 1'b0;
      #1;
      chk("t7_async", 32'(imem.imem_req), 32'd0);
      chk("t7_iv", 32'(iv), 32'd0);
      do_reset();
      push_seq(32'h0, 2);
      step();
      @(negedge clk);
      chk("t7_addr", imem.imem_addr, 32'h0);
      chk("t7_rreq", 32'(imem.imem_req), 32'd1);
      wait_pops("t7_pops", 1, 30);
      stall = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
